ex_stage: RTL
=============

# ex_stage

Execute stage of the MIPS32 five-stage pipeline. It consumes the ID/EX pipeline register outputs and computes the ALU result forwarded to the EX/MEM register. It owns the architectural HI/LO registers and an iterative divider. While a divide is in flight it raises a stall request so that the upstream stages hold.

## Interface
Parameters:
- DIV_CYCLES, 32, number of divider iterations. Fixed at 32 for 32-bit operands; not to be overridden.

Ports:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- ex_rdata1  in  32  operand A (rs)
- ex_rdata2  in  32  operand B (rt)
- ex_ext_imm  in  32  extended immediate; bits [10:6] carry shamt for R-type shifts
- ex_aluop  in  4  operation code (see Operation)
- ex_instr_type  in  2  R=00, I=01, J=10; R selects rdata2 as operand B, I selects ext_imm
- ex_to_hi  in  1  MTHI: HI <= rdata1
- ex_to_lo  in  1  MTLO: LO <= rdata1
- ex_alu_result  out  32  combinational result to EX/MEM
- ex_stall_req  out  1  hold IF/ID/EX inputs this cycle
- ex_hi  out  32  current HI register
- ex_lo  out  32  current LO register

## Operation
- aluop codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: 32-bit wrap, no overflow trap.
  - 5 MFHI, 6 SLT (signed), 7 SLTU: SLT/SLTU result is 0 or 1.
  - 8 SLL, 9 SRL, A SRA: shift rdata2 by ext_imm[10:6].
  - B MFLO.
  - C MULT, D MULTU, E DIV, F DIVU.
- MULT/MULTU: single-cycle 64-bit product; {HI,LO} written at the clock edge. ex_alu_result = 0. No stall.
- DIV/DIVU divider FSM:
  - IDLE: on DIV/DIVU at input, latch operands and signedness, assert ex_stall_req, go to BUSY with count=0.
  - BUSY: one restoring quotient bit per cycle, ex_stall_req=1. When count==DIV_CYCLES-1, go to DONE.
  - DONE: LO <= quotient, HI <= remainder, ex_stall_req=0, go to IDLE. The held DIV leaves EX at this edge and is not restarted.
- Signed divide: operate on magnitudes. Quotient is negated when operand signs differ; remainder takes the dividend's sign.
- Divide by zero: LO=0xFFFFFFFF, HI=dividend (unsigned); the signed case uses the same raw result before sign fix.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- MTHI/MTLO: write at the edge and may be asserted together. HI/LO writes are ignored while the FSM is not IDLE.
- MFHI/MFLO read the registered value. Writes become visible to the next instruction; no internal bypass is needed.

## Timing
- Reset values: HI=0, LO=0, FSM=IDLE, count=0, ex_stall_req=0, ex_hi=0, ex_lo=0. ex_alu_result follows its inputs combinationally.
- ALU ops and MULT: latency 0 (combinational) / HI-LO update at the next edge.
- DIV: presented in cycle N. ex_stall_req is high in cycles N..N+32. DONE is cycle N+33. New HI/LO are visible from cycle N+34.
- Upstream must hold all inputs constant while ex_stall_req=1.
- rst during BUSY/DONE: abort, return to IDLE, stall drops the following cycle, HI/LO cleared.
- Back-to-back DIVs: the second starts from IDLE in cycle N+34.

## Configuration
- EX_MULDIV_EN defined: MULT/MULTU/DIV/DIVU implemented as above.
- EX_MULDIV_EN undefined:
  - codes C–F act as NOP: result 0, no HI/LO write.
  - ex_stall_req is tied 0 and the divider is not instantiated.
  - MTHI/MTLO/MFHI/MFLO remain functional.

## Structure
- Shared header definations.vh holds the aluop codes, the instr_type codes (type_r, type_i, type_j) and DIV_CYCLES.
- One sub-module, ex_div: the FSM, counter and restoring datapath.
  - Interface: start, signed, dividend, divisor, busy, done, quotient, remainder.
- ex_stage holds the ALU mux, multiplier, HI/LO registers and stall logic.

## Test plan
- ADD 0x7FFFFFFF+1 -> 0x80000000. SLT 0xFFFFFFFF vs 1 -> 1. SLTU on the same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MULT -2 × 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA the next cycle, no stall. MULTU 0xFFFFFFFF² -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> stall high for exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- rst asserted at BUSY count 10 -> IDLE next cycle, stall 0, HI=LO=0. A subsequent MTHI 0x1234 followed by MFHI -> result 0x1234.
- Build without EX_MULDIV_EN: DIV -> no stall, HI/LO unchanged, result 0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage shared definitions: aluop and instr_type codes,
// divider iteration count and a conditional-negate helper.
package ex_stage_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_MFHI  = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_SLTU  = 4'h7;
  localparam logic [3:0] OP_SLL   = 4'h8;
  localparam logic [3:0] OP_SRL   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_MFLO  = 4'hB;
  localparam logic [3:0] OP_MULT  = 4'hC;
  localparam logic [3:0] OP_MULTU = 4'hD;
  localparam logic [3:0] OP_DIV   = 4'hE;
  localparam logic [3:0] OP_DIVU  = 4'hF;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  localparam int DIV_CYCLES = 32;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand bundle into the execute stage and its
// result/HI/LO/stall outputs back to the pipeline.
interface ex_stage_if;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_ext_imm;
  logic [3:0]  ex_aluop;
  logic [1:0]  ex_instr_type;
  logic        ex_to_hi;
  logic        ex_to_lo;
  logic [31:0] ex_alu_result;
  logic        ex_stall_req;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;

  modport master (
    output ex_rdata1, ex_rdata2, ex_ext_imm,
    output ex_aluop, ex_instr_type,
    output ex_to_hi, ex_to_lo,
    input  ex_alu_result, ex_stall_req,
    input  ex_hi, ex_lo
  );

  modport slave (
    input  ex_rdata1, ex_rdata2, ex_ext_imm,
    input  ex_aluop, ex_instr_type,
    input  ex_to_hi, ex_to_lo,
    output ex_alu_result, ex_stall_req,
    output ex_hi, ex_lo
  );
endinterface

// File: rtl/ex_stage_div.sv
// ex_div: restoring divider, one quotient bit per cycle.
// Only built when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        sign_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [32:0]   shf, dif;
  logic          a_neg, b_neg;

  assign a_neg = sign_i & dividend_i[31];
  assign b_neg = sign_i & divisor_i[31];

  // next state: latch magnitudes, then shift/subtract per cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    shf     = {rem_q, quo_q[31]};
    dif     = shf - {1'b0, dvs_q};
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          quo_d   = neg_if(a_neg, dividend_i);
          dvs_d   = neg_if(b_neg, divisor_i);
          rem_d   = '0;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = dif[32] ? shf[31:0] : dif[31:0];
        quo_d = {quo_q[30:0], ~dif[32]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_CYCLES - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy_o      = (state_q == S_BUSY);
  assign done_o      = (state_q == S_DONE);
  assign quotient_o  = neg_if(negq_q, quo_q);
  assign remainder_o = neg_if(negr_q, rem_q);

endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS32 execute stage: ALU, HI/LO, multiplier and divider.
// Mul/div (and stall) present only if EX_MULDIV_EN is defined.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_stage_if.slave bus
);

  logic [31:0] a, b, opb;
  logic [4:0]  sh;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res;
  logic        md_idle;

  assign a   = bus.ex_rdata1;
  assign b   = bus.ex_rdata2;
  assign sh  = bus.ex_ext_imm[10:6];
  assign opb = (bus.ex_instr_type == TYPE_R) ? b
                                             : bus.ex_ext_imm;

  // combinational ALU result; mul/div codes yield 0
  always_comb begin
    res = '0;
    unique case (bus.ex_aluop)
      OP_ADD:  res = a + opb;
      OP_SUB:  res = a - opb;
      OP_AND:  res = a & opb;
      OP_OR:   res = a | opb;
      OP_XOR:  res = a ^ opb;
      OP_MFHI: res = hi_q;
      OP_SLT:  res = {31'd0, $signed(a) < $signed(opb)};
      OP_SLTU: res = {31'd0, a < opb};
      OP_SLL:  res = b << sh;
      OP_SRL:  res = b >> sh;
      OP_SRA:  res = $signed(b) >>> sh;
      OP_MFLO: res = lo_q;
      default: res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic        mul_op, div_op, div_start;
  logic        div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [63:0] prod, ma, mb;
  logic        msg;

  assign mul_op = (bus.ex_aluop == OP_MULT) |
                  (bus.ex_aluop == OP_MULTU);
  assign div_op = (bus.ex_aluop == OP_DIV) |
                  (bus.ex_aluop == OP_DIVU);
  assign msg    = (bus.ex_aluop == OP_MULT);
  assign ma     = {{32{msg & a[31]}}, a};
  assign mb     = {{32{msg & b[31]}}, b};
  assign prod   = ma * mb;

  assign md_idle   = ~div_busy & ~div_done;
  assign div_start = md_idle & div_op & ~rst;

  ex_div u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .sign_i      (bus.ex_aluop == OP_DIV),
    .dividend_i  (a),
    .divisor_i   (b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  assign bus.ex_stall_req = div_start | div_busy;
`else
  assign md_idle          = 1'b1;
  assign bus.ex_stall_req = 1'b0;
`endif

  // HI/LO next value: MTHI/MTLO, MULT, divider completion
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_idle) begin
      if (bus.ex_to_hi) hi_d = a;
      if (bus.ex_to_lo) lo_d = a;
    end
`ifdef EX_MULDIV_EN
    if (md_idle && mul_op) begin
      {hi_d, lo_d} = prod;
    end
    if (div_done) begin
      hi_d = div_r;
      lo_d = div_q;
    end
`endif
  end

  // architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.ex_alu_result = res;
  assign bus.ex_hi         = hi_q;
  assign bus.ex_lo         = lo_q;

endmodule
